tribus_arbiter: RTL

Round-robin arbiter for a shared tri-state bus driven by N sources, each driving through its own conditional buffer onto one net. It issues one-hot grants and buffer enables so that at most one driver is ever enabled. It inserts turnaround cycles with all enables off between owners, so the bus never sees two drivers (contention, X) during handover. It caps each ownership with a hold timeout.

---
 rtl/tribus_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: one-hot grants/enables, turnaround gaps
// between owners and a per-ownership hold timeout.
module tribus_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN     = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   oe,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic           timeout
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam int unsigned GW = $clog2(TURN + 1);

    typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [GW-1:0]  gap_q, gap_d;

    logic           win_found;
    logic [IDW-1:0] win_idx, win_next, cand;
    logic           rel_normal, rel_limit, release_now, gap_last, arb_en;

    // Rotating priority scan starting at ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDW'((32'(ptr_q) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_next = (win_idx == IDW'(N - 1)) ? '0 : IDW'(win_idx + 1'b1);
    end

    assign rel_normal  = done[owner_q] || !req[owner_q];
    assign rel_limit   = (hold_q == HW'(MAX_HOLD));
    assign release_now = rel_normal || rel_limit;
    assign gap_last    = (gap_q == GW'(TURN));
    assign arb_en      = (state_q == StIdle) || ((state_q == StGap) && gap_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = win_found ? StOwn : StIdle;
            StOwn:   state_d = release_now ? StGap : StOwn;
            StGap: begin
                if (gap_last) begin
                    state_d = win_found ? StOwn : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        if (arb_en && win_found) begin
            gnt_d   = N'(1) << win_idx;
            owner_d = win_idx;
            ptr_d   = win_next;
            busy_d  = 1'b1;
            hold_d  = HW'(1);
        end else if (state_q == StOwn) begin
            if (release_now) begin
                gnt_d     = '0;
                busy_d    = 1'b0;
                hold_d    = '0;
                gap_d     = GW'(1);
                // Pulse only when the limit alone ended the ownership.
                timeout_d = rel_limit && !rel_normal;
            end else begin
                hold_d = HW'(hold_q + 1'b1);
            end
        end else if ((state_q == StGap) && !gap_last) begin
            gap_d = GW'(gap_q + 1'b1);
        end
    end

    assign gnt     = gnt_q;
    assign oe      = gnt_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign timeout = timeout_q;

endmodule
